// File: rtl/mining_pkg.sv
// mining_pkg: shared sizes and dispatcher state encoding for the mining UART protocol.
package mining_pkg;
   localparam int BLOCK_BYTES = 76;
   localparam int NONCE_BYTES = 4;
   localparam int BLOCK_BITS  = BLOCK_BYTES * 8;
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_TX, RECV} dispatch_state_t;
endpackage

// File: rtl/wd_timeout.sv
// wd_timeout: saturating reply-silence counter that flags the cycle the limit is hit.
module wd_timeout #(
   parameter int TIMEOUT_CLKS = 200_000_000
) (
   input  logic clk,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int W = $clog2(TIMEOUT_CLKS);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      if (!rst_i || clear) cnt <= '0;
      else if (enable && cnt != '1) cnt <= cnt + 1'b1;
   assign expire = enable && cnt == W'(TIMEOUT_CLKS - 1);
endmodule

// File: rtl/work_dispatcher.sv
// work_dispatcher: streams a 76-byte header to uart_tx and collects the 4-byte nonce reply.
module work_dispatcher
   import mining_pkg::*;
#(
   parameter int TIMEOUT_CLKS = 200_000_000
) (
   input  logic                  clk,
   input  logic                  rst_i,
   input  logic                  start,
   input  logic [BLOCK_BITS-1:0] block_in,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic [31:0]           nonce_out,
   output logic                  tx_dv,
   output logic [7:0]            tx_byte,
   input  logic                  tx_done,
   input  logic                  rx_dv,
   input  logic [7:0]            rx_byte
);
   dispatch_state_t       state;
   logic [BLOCK_BITS-1:0] shreg;
   logic [6:0]            tx_idx;
   logic [2:0]            rx_cnt;
   logic [31:0]           nonce_sh;
   logic                  in_recv;
   logic                  expire;
   logic                  last_byte;

   assign in_recv   = state == RECV;
   assign last_byte = tx_idx == 7'(BLOCK_BYTES - 1);
   assign tx_dv     = state == LAUNCH;
   assign tx_byte   = (state == LAUNCH || state == WAIT_TX) ? shreg[7:0] : 8'h00;

   // silence counter only runs in RECV; any received byte restarts it
   wd_timeout #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_tmo (
      .clk    (clk),
      .rst_i  (rst_i),
      .clear  (!in_recv || rx_dv),
      .enable (in_recv && !rx_dv),
      .expire (expire)
   );

   always_ff @(posedge clk)
      if (!rst_i) begin
         state     <= IDLE;
         shreg     <= '0;
         tx_idx    <= '0;
         rx_cnt    <= '0;
         nonce_sh  <= '0;
         nonce_out <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  shreg  <= block_in;
                  busy   <= 1'b1;
                  tx_idx <= '0;
                  state  <= LAUNCH;
               end
            LAUNCH: state <= WAIT_TX;
            WAIT_TX:
               if (tx_done) begin
                  shreg  <= shreg >> 8;
                  tx_idx <= last_byte ? tx_idx : tx_idx + 1'b1;
                  rx_cnt <= '0;
                  state  <= last_byte ? RECV : LAUNCH;
               end
            RECV:
               if (rx_cnt == 3'(NONCE_BYTES)) begin
                  nonce_out <= nonce_sh;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else if (rx_dv) begin
                  nonce_sh <= {nonce_sh[23:0], rx_byte};
                  rx_cnt   <= rx_cnt + 1'b1;
               end else if (expire) begin
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule
